stopwatch_button_conditioner: RTL and testbench
===============================================

# stopwatch_button_conditioner

Front-end stage for the stopwatch. It takes the two raw, asynchronous, bouncing push-button inputs, synchronizes and debounces each one, and emits a single-cycle press pulse per qualified press. Its pulse outputs connect directly to the stopwatch FSM's `start_stop` and `reset_btn` inputs, and both blocks share the same clock.

## Interface
- `DEBOUNCE_CYCLES`, default 3: consecutive synchronized-high (or low) cycles needed to qualify a press (or release). Legal range 1 to 2^`CNT_W`.
- `CNT_W`, default 8: width of each debounce counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-low. Sampled only on `clk` rising edge.
- `btn_start_raw` in 1: raw start/stop button. Asynchronous, active-high, bouncing.
- `btn_reset_raw` in 1: raw reset button. Asynchronous, active-high, bouncing.
- `start_stop` out 1: one-cycle pulse per qualified start/stop press.
- `reset_btn` out 1: one-cycle pulse per qualified reset press.
- `start_level` out 1: debounced level of the start/stop button.
- `reset_level` out 1: debounced level of the reset button.

## Operation
- Each channel is independent and identical: a 2-FF synchronizer (`s1`, `s2`) feeding a 4-state FSM with a `CNT_W` counter.
- FSM states:
  - IDLE (level=0): if `s2`=1, go to ARM with cnt=0.
  - ARM (level=0): if `s2`=0, return to IDLE. Else, if cnt==`DEBOUNCE_CYCLES`-1, go to PRESSED and assert the pulse. Else cnt+1.
  - PRESSED (level=1): if `s2`=0, go to DISARM with cnt=0.
  - DISARM (level=1): if `s2`=1, return to PRESSED. Else, if cnt==`DEBOUNCE_CYCLES`-1, go to IDLE. Else cnt+1.
- The pulse is registered. It is high for exactly the one cycle following the ARM→PRESSED edge.
- Exactly one pulse per press. Holding a button in PRESSED never produces a repeat pulse.
- A bounce back to 0 during ARM, or back to 1 during DISARM, aborts qualification. No pulse results, and the level does not change.
- The counter never wraps. It stops advancing at `DEBOUNCE_CYCLES`-1 because the state changes on that compare.
- Simultaneous qualification (both pulses would rise in the same cycle):
  - `start_stop` pulses and `reset_btn` is suppressed for that press.
  - The reset channel still enters PRESSED and `reset_level` still goes to 1.
  - This matches the stopwatch's start_stop priority and prevents a dropped reset being misread.
- Reset (`rst`=0 at a clock edge):
  - All synchronizer FFs clear to 0.
  - Both FSMs go to IDLE and both counters clear to 0.
  - All four outputs go to 0 in the following cycle.
  - Reset mid-ARM or mid-PRESSED discards the state, with no pulse.
- A button held through reset release re-qualifies from IDLE and produces one pulse. This is intended.

## Timing
- Reset values: `start_stop`=0, `reset_btn`=0, `start_level`=0, `reset_level`=0.
- Press latency:
  - Counting edges, edge 1 is the first `clk` edge that samples the raw input high.
  - The pulse register is set at edge 3+`DEBOUNCE_CYCLES`, which is edge 6 with the defaults.
  - The level rises on that same edge.
  - Requires raw=1 at every edge from 1 through 1+`DEBOUNCE_CYCLES`.
- Release latency: the level falls at edge 3+`DEBOUNCE_CYCLES` after the first edge that samples raw low. Requires raw=0 held for `DEBOUNCE_CYCLES`+1 edges.
- Pulse width is exactly 1 cycle. Minimum spacing between two pulses on one channel is 2·(`DEBOUNCE_CYCLES`+1) cycles.
- No combinational path from any input to any output. All outputs are flops.

## Structure
- Shared `stopwatch_pkg`:
  - `btn_state_t` enum: IDLE=2'b00, ARM=2'b01, PRESSED=2'b10, DISARM=2'b11.
  - Default `DEBOUNCE_CYCLES` constant.
- Sub-module `debounce_channel`:
  - Contains the synchronizer, FSM and counter.
  - Outputs `pulse_raw` and `level`.
  - Instantiated twice.
- The top level holds only the simultaneous-pulse arbitration and the output registers.

## Test plan
- Clean press with `DEBOUNCE_CYCLES`=3: raw start goes high at edge 1 and is held 20 cycles. Required: `start_stop`=1 only in the cycle after edge 6. `start_level` rises at edge 6 and stays 1. `reset_btn` stays 0.
- Bounce: raw reset toggles 1,0,1,0 on edges 1–4, then holds 1 from edge 5. Required: exactly one `reset_btn` pulse, set at edge 10. No earlier pulse.
- Short glitch: raw start is high for 3 edges (less than `DEBOUNCE_CYCLES`+1), then low. Required: no pulse, and `start_level` stays 0 throughout.
- Simultaneous press: both raw inputs rise at edge 1 and are held. Required:
  - `start_stop` pulses after edge 6.
  - `reset_btn` never pulses.
  - Both levels are 1 from edge 6.
- Reset mid-operation: raw start is high from edge 1, and `rst`=0 at edge 4 for 2 cycles. Required:
  - All outputs are 0 after edge 4.
  - After release, start re-qualifies and exactly one pulse follows, 3+`DEBOUNCE_CYCLES` edges after the first post-reset edge.
- Release and repress: press, release 2 cycles (bounce), press again. Required: one pulse only, and `start_level` stays 1 through the bounce.

Source files
------------

// File: rtl/stopwatch_button_conditioner_pkg.sv
// Shared types and defaults for the stopwatch front end.
// The encoding puts the debounced level in state bit 1.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARM     = 2'b01,
        PRESSED = 2'b10,
        DISARM  = 2'b11
    } btn_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 3;
    localparam int CNT_W_DEF           = 8;

endpackage

// File: rtl/stopwatch_button_conditioner_if.sv
// Button conditioner signal bundle: raw buttons in, press pulses/levels out.
// The raw buttons have no handshake. Pulses are single-cycle strobes, and levels are steady debounced states.
interface stopwatch_button_conditioner_if;
    import stopwatch_pkg::*;

    logic       btn_start_raw;
    logic       btn_reset_raw;
    logic       start_stop;
    logic       reset_btn;
    logic       start_level;
    logic       reset_level;
    btn_state_t start_state;
    btn_state_t reset_state;

    modport master (
        output btn_start_raw, btn_reset_raw,
        input  start_stop, reset_btn, start_level, reset_level,
        input  start_state, reset_state
    );

    modport slave (
        input  btn_start_raw, btn_reset_raw,
        output start_stop, reset_btn, start_level, reset_level,
        output start_state, reset_state
    );
endinterface

// File: rtl/stopwatch_button_conditioner_channel.sv
// One button channel: 2-FF synchronizer, debounce FSM and qualification counter.
// pulse_raw_o is combinational and is registered by the top.
module debounce_channel
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_i,
    output logic       pulse_raw_o,
    output logic       level_o,
    output btn_state_t state_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1_q;
    logic             s2_q;
    btn_state_t       state_q;
    btn_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter stops at CNT_LAST because the state always leaves on that compare.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pulse_raw_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
            end
            ARM: begin
                if (!s2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = PRESSED;
                    pulse_raw_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s2_q) begin
                    state_d = DISARM;
                    cnt_d   = '0;
                end
            end
            DISARM: begin
                if (s2_q) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign level_o = state_q[1];
    assign state_o = state_q;

endmodule

// File: rtl/stopwatch_button_conditioner.sv
// Two debounced button channels with start/stop-priority pulse arbitration.
// The levels come straight from the channel state flops, and the pulses are re-registered here.
module stopwatch_button_conditioner
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    stopwatch_button_conditioner_if.slave bus
);

    logic       start_pulse_raw;
    logic       reset_pulse_raw;
    logic       start_level;
    logic       reset_level;
    btn_state_t start_state;
    btn_state_t reset_state;
    logic       start_stop_q;
    logic       start_stop_d;
    logic       reset_btn_q;
    logic       reset_btn_d;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_start (
        .clk         (clk),
        .rst         (rst),
        .raw_i       (bus.btn_start_raw),
        .pulse_raw_o (start_pulse_raw),
        .level_o     (start_level),
        .state_o     (start_state)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_reset (
        .clk         (clk),
        .rst         (rst),
        .raw_i       (bus.btn_reset_raw),
        .pulse_raw_o (reset_pulse_raw),
        .level_o     (reset_level),
        .state_o     (reset_state)
    );

    // If both qualify together, start/stop wins and this reset press is dropped.
    always_comb begin
        start_stop_d = start_pulse_raw;
        reset_btn_d  = reset_pulse_raw & ~start_pulse_raw;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            start_stop_q <= 1'b0;
            reset_btn_q  <= 1'b0;
        end else begin
            start_stop_q <= start_stop_d;
            reset_btn_q  <= reset_btn_d;
        end
    end

    assign bus.start_stop  = start_stop_q;
    assign bus.reset_btn   = reset_btn_q;
    assign bus.start_level = start_level;
    assign bus.reset_level = reset_level;
    assign bus.start_state = start_state;
    assign bus.reset_state = reset_state;

endmodule

// File: tb/tb_stopwatch_button_conditioner.sv
// Directed vector bench for the button conditioner (DEBOUNCE_CYCLES = 3).
// Edge numbers count rising edges from the start of each scenario.
module tb_stopwatch_button_conditioner;

    typedef struct packed {
        logic s;
        logic r;
        logic rst_n;
        logic ss;
        logic rb;
        logic sl;
        logic rl;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    vec_t vecs[$];
    logic [3:0] exp_q[$];

    stopwatch_button_conditioner_if sw_if ();

    stopwatch_button_conditioner #(
        .DEBOUNCE_CYCLES (3),
        .CNT_W           (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached, want summary before 1ms");
        $fatal(1, "watchdog");
    end

    function automatic void add(input logic s, input logic r, input logic rst_n,
                                input logic ss, input logic rb, input logic sl, input logic rl);
        vec_t v;
        v = '{s: s, r: r, rst_n: rst_n, ss: ss, rb: rb, sl: sl, rl: rl};
        vecs.push_back(v);
    endfunction

    task automatic step(input logic s, input logic r, input logic rst_n);
        @(negedge clk);
        sw_if.btn_start_raw = s;
        sw_if.btn_reset_raw = r;
        rst = rst_n;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        total++;
        if (act !== exp)
            $display("FAIL %s @%0d: got %0b want %0b", name, idx, act, exp);
        else
            passed++;
    endtask

    task automatic check_outs(input string tag, input int idx, input logic [3:0] exp);
        check({tag, ".start_stop"}, idx, sw_if.start_stop, exp[3]);
        check({tag, ".reset_btn"}, idx, sw_if.reset_btn, exp[2]);
        check({tag, ".start_level"}, idx, sw_if.start_level, exp[1]);
        check({tag, ".reset_level"}, idx, sw_if.reset_level, exp[0]);
    endtask

    initial begin
        logic [3:0] e4;
        total  = 0;
        passed = 0;
        sw_if.btn_start_raw = 1'b0;
        sw_if.btn_reset_raw = 1'b0;
        rst = 1'b0;

        // Clean press held 20 cycles, then release.
        for (int e = 1; e <= 20; e++) add(1, 0, 1, e == 6, 0, e >= 6, 0);
        for (int e = 1; e <= 8; e++)  add(0, 0, 1, 0, 0, e < 6, 0);
        // Bouncing reset button: 1,0,1,0 then steady high.
        for (int e = 1; e <= 14; e++) begin
            logic rv;
            rv = (e >= 5) ? 1'b1 : ((e % 2) == 1);
            add(0, rv, 1, 0, e == 10, 0, e >= 10);
        end
        for (int e = 1; e <= 8; e++)  add(0, 0, 1, 0, 0, 0, e < 6);
        // Glitch of three samples: too short to qualify.
        for (int e = 1; e <= 12; e++) add(e <= 3, 0, 1, 0, 0, 0, 0);
        // Simultaneous press: start/stop wins, reset level still follows.
        for (int e = 1; e <= 12; e++) add(1, 1, 1, e == 6, 0, e >= 6, e >= 6);
        for (int e = 1; e <= 8; e++)  add(0, 0, 1, 0, 0, e < 6, e < 6);

        step(0, 0, 0);
        check_outs("reset", 0, 4'b0000);
        step(0, 0, 0);
        check_outs("reset", 1, 4'b0000);
        step(0, 0, 1);
        check_outs("post_reset", 2, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            exp_q.push_back({vecs[i].ss, vecs[i].rb, vecs[i].sl, vecs[i].rl});
            step(vecs[i].s, vecs[i].r, vecs[i].rst_n);
            e4 = exp_q.pop_front();
            check_outs("vec", i, e4);
        end

        // Reset asserted mid-ARM for two edges, start held throughout.
        for (int e = 1; e <= 15; e++) begin
            step(1, 0, !(e == 4 || e == 5));
            check_outs("rst_mid", e, {e == 11, 1'b0, e >= 11, 1'b0});
        end
        for (int e = 1; e <= 8; e++) begin
            step(0, 0, 1);
            check_outs("rst_mid_rel", e, {1'b0, 1'b0, e < 6, 1'b0});
        end

        // Press, two-cycle release bounce, press again: one pulse, level held.
        for (int e = 1; e <= 20; e++) begin
            step(!(e == 9 || e == 10), 0, 1);
            check_outs("repress", e, {e == 6, 1'b0, e >= 6, 1'b0});
        end
        for (int e = 1; e <= 8; e++) begin
            step(0, 0, 1);
            check_outs("repress_rel", e, {1'b0, 1'b0, e < 6, 1'b0});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
